cr_prefix_fe_accum: RTL

- Sits directly downstream of a bank of N_CMP per-character comparator stages in the prefix feature-extraction front end.
- Consumes their registered match bits (cmp_r) and the shared registered char valid.
- Accumulates saturating per-comparator match counts and a record character count over one record, delimited by char_last.
- Presents the per-record feature vector on a valid/ready output, with two-deep buffering because the comparator stages cannot be back-pressured.

---
 rtl/cr_prefix_fe_accum_if.sv | 25 ++
 rtl/cr_prefix_fe_accum.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cr_prefix_fe_accum_if.sv
// Feature-vector output bus of cr_prefix_fe_accum (valid/ready plus record payload).
// Optional out_first lane is present only when CR_PREFIX_FE_ACCUM_FIRST_EN is defined.
interface cr_prefix_fe_accum_if #(
    parameter int N_CMP  = 4,
    parameter int CNT_W  = 8,
    parameter int CHAR_W = 16
);
    logic                     out_valid;
    logic                     out_ready;
    logic [N_CMP*CNT_W-1:0]   out_cnt;
    logic [CHAR_W-1:0]        out_char_cnt;
`ifdef CR_PREFIX_FE_ACCUM_FIRST_EN
    logic [N_CMP-1:0]         out_first;

    modport master (output out_valid, output out_cnt, output out_char_cnt,
                    output out_first, input out_ready);
    modport slave  (input out_valid, input out_cnt, input out_char_cnt,
                    input out_first, output out_ready);
`else
    modport master (output out_valid, output out_cnt, output out_char_cnt,
                    input out_ready);
    modport slave  (input out_valid, input out_cnt, input out_char_cnt,
                    output out_ready);
`endif
endinterface

// File: rtl/cr_prefix_fe_accum.sv
// Per-record saturating match/char accumulator with a two-deep (OUT + SKID) output buffer.
// Optional macro CR_PREFIX_FE_ACCUM_FIRST_EN adds out_first (cmp_r of the record's first char).
module cr_prefix_fe_accum #(
    parameter int N_CMP  = 4,
    parameter int CNT_W  = 8,
    parameter int CHAR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CMP-1:0]      cmp_r,
    input  logic                  char_valid_r,
    input  logic                  char_last,
    cr_prefix_fe_accum_if.master  o_bus,
    output logic                  drop_pulse,
    output logic [15:0]           drop_cnt
);
    localparam int CNTS_W = N_CMP * CNT_W;
`ifdef CR_PREFIX_FE_ACCUM_FIRST_EN
    localparam int REC_W  = N_CMP + CNTS_W + CHAR_W;
`else
    localparam int REC_W  = CNTS_W + CHAR_W;
`endif

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t              r_state, w_state_next;
    logic [CNTS_W-1:0]   r_acc;
    logic [CNTS_W-1:0]   w_acc_next;
    logic [CHAR_W-1:0]   r_char_acc;
    logic [CHAR_W-1:0]   w_char_next;
    logic [REC_W-1:0]    w_rec;
    logic [REC_W-1:0]    r_out, r_skid;
    logic                r_drop_pulse;
    logic [15:0]         r_drop_cnt;
    logic                w_done, w_drain;
    logic                w_load_out_new, w_load_out_skid, w_load_skid, w_drop;

    assign w_done  = char_valid_r & char_last;
    assign w_drain = (r_state != S_EMPTY) & o_bus.out_ready;

    // Completion value already includes the current char.
    for (genvar gi = 0; gi < N_CMP; gi++) begin : g_lane
        assign w_acc_next[gi*CNT_W +: CNT_W] =
            (cmp_r[gi] && (r_acc[gi*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
                ? r_acc[gi*CNT_W +: CNT_W] + CNT_W'(1)
                : r_acc[gi*CNT_W +: CNT_W];
    end

    assign w_char_next = (r_char_acc == {CHAR_W{1'b1}}) ? r_char_acc
                                                        : r_char_acc + CHAR_W'(1);

`ifdef CR_PREFIX_FE_ACCUM_FIRST_EN
    logic [N_CMP-1:0] r_first;
    logic [N_CMP-1:0] w_first_next;

    assign w_first_next = (r_char_acc == '0) ? cmp_r : r_first;
    assign w_rec        = {w_first_next, w_acc_next, w_char_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_first <= '0;
        else if (char_valid_r) r_first <= w_first_next;
    end

    assign o_bus.out_first = r_out[CNTS_W + CHAR_W +: N_CMP];
`else
    assign w_rec = {w_acc_next, w_char_next};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_char_acc <= '0;
        end else if (char_valid_r) begin
            r_acc      <= w_done ? '0 : w_acc_next;
            r_char_acc <= w_done ? '0 : w_char_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        w_load_out_new  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        w_drop          = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_done) begin
                    w_load_out_new = 1'b1;
                    w_state_next   = S_ONE;
                end
            end
            S_ONE: begin
                if (w_done && w_drain) begin
                    w_load_out_new = 1'b1;
                end else if (w_done) begin
                    w_load_skid  = 1'b1;
                    w_state_next = S_TWO;
                end else if (w_drain) begin
                    w_state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_drain) begin
                    w_load_out_skid = 1'b1;
                    w_load_skid     = w_done;
                    w_state_next    = w_done ? S_TWO : S_ONE;
                end else if (w_done) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out_new)       r_out <= w_rec;
            else if (w_load_out_skid) r_out <= r_skid;
            if (w_load_skid)          r_skid <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_bus.out_valid    = (r_state != S_EMPTY);
    assign o_bus.out_cnt      = r_out[CHAR_W +: CNTS_W];
    assign o_bus.out_char_cnt = r_out[CHAR_W-1:0];
    assign drop_pulse         = r_drop_pulse;
    assign drop_cnt           = r_drop_cnt;
endmodule
